// File: rtl/elementwise_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elementwise_mul_ctrl
// Description : Row-streaming sequencer for a 4x4 element-wise multiplier.
//               Optional done counter enabled by macro ELEMWISE_CTRL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module elementwise_mul_ctrl #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_clear,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [4*W-1:0]    i_row_u,
   input  logic [4*W-1:0]    i_row_v,
   output logic [16*W-1:0]   o_mtx_u,
   output logic [16*W-1:0]   o_mtx_v,
   input  logic [32*W-1:0]   i_mtx_m,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [8*W-1:0]    o_row_m,
`ifdef ELEMWISE_CTRL_CNT_EN
   output logic [CNT_W-1:0]  o_done_cnt,
`endif
   output logic              o_busy
);

   localparam logic [1:0] c_LOAD  = 2'd0;
   localparam logic [1:0] c_CALC  = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        r_row;
   logic [16*W-1:0]   r_mtx_u;
   logic [16*W-1:0]   r_mtx_v;
   logic [32*W-1:0]   r_result;
   int unsigned       w_row_idx;
   logic              w_last_out;

   assign w_row_idx   = 32'(r_row);
   assign o_in_ready  = (r_state == c_LOAD);
   assign o_out_valid = (r_state == c_DRAIN);
   assign o_busy      = (r_state != c_LOAD);
   assign o_mtx_u     = r_mtx_u;
   assign o_mtx_v     = r_mtx_v;
   assign o_row_m     = r_result[w_row_idx*8*W +: 8*W];
   // Final accepted output beat of a matrix; a same-cycle clear cancels it.
   assign w_last_out  = !i_clear && (r_state == c_DRAIN) && i_out_ready && (r_row == 2'd3);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= c_LOAD;
         r_row    <= 2'd0;
         r_mtx_u  <= '0;
         r_mtx_v  <= '0;
         r_result <= '0;
      end else if (i_clear) begin
         r_state <= c_LOAD;
         r_row   <= 2'd0;
      end else begin
         case (r_state)
            c_LOAD: begin
               if (i_in_valid) begin
                  r_mtx_u[w_row_idx*4*W +: 4*W] <= i_row_u;
                  r_mtx_v[w_row_idx*4*W +: 4*W] <= i_row_v;
                  r_row <= r_row + 2'd1;
                  if (r_row == 2'd3) begin
                     r_state <= c_CALC;
                  end
               end
            end
            c_CALC: begin
               r_result <= i_mtx_m;
               r_state  <= c_DRAIN;
            end
            c_DRAIN: begin
               if (i_out_ready) begin
                  r_row <= r_row + 2'd1;
                  if (r_row == 2'd3) begin
                     r_state <= c_LOAD;
                  end
               end
            end
            default: begin
               r_state <= c_LOAD;
               r_row   <= 2'd0;
            end
         endcase
      end
   end

`ifdef ELEMWISE_CTRL_CNT_EN
   logic [CNT_W-1:0] r_done_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_done_cnt <= '0;
      end else if (w_last_out) begin
         r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
   end

   assign o_done_cnt = r_done_cnt;
`else
   localparam int c_unused_cnt_w = CNT_W;
   logic w_unused_last_out;
   assign w_unused_last_out = w_last_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_elementwise_mul_ctrl.sv
`default_nettype none
// Testbench for elementwise_mul_ctrl: behavioural matrix model plus directed
// and randomized row streams.
module tb_elementwise_mul_ctrl;
   localparam int W     = 8;
   localparam int CNT_W = 16;

   logic            clk = 1'b0;
   logic            rstn;
   logic            i_clear, i_in_valid, i_out_ready;
   logic [4*W-1:0]  i_row_u, i_row_v;
   logic [16*W-1:0] o_mtx_u, o_mtx_v;
   logic [32*W-1:0] i_mtx_m;
   logic            o_in_ready, o_out_valid, o_busy;
   logic [8*W-1:0]  o_row_m;
   logic [CNT_W-1:0] o_done_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   elementwise_mul_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .i_clear(i_clear),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_row_u(i_row_u), .i_row_v(i_row_v),
      .o_mtx_u(o_mtx_u), .o_mtx_v(o_mtx_v), .i_mtx_m(i_mtx_m),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_row_m(o_row_m),
`ifdef ELEMWISE_CTRL_CNT_EN
      .o_done_cnt(o_done_cnt),
`endif
      .o_busy(o_busy)
   );
`ifndef ELEMWISE_CTRL_CNT_EN
   assign o_done_cnt = '0;
`endif

   // Parent-side combinational multiplier
   always_comb begin
      i_mtx_m = '0;
      for (int k = 0; k < 16; k++)
         i_mtx_m[k*16 +: 16] = 16'(o_mtx_u[k*8 +: 8]) * 16'(o_mtx_v[k*8 +: 8]);
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]       m_u [16];
   logic [7:0]       m_v [16];
   int               m_rows;
   bit               m_calc;
   logic [63:0]      m_out [$];
   logic [CNT_W-1:0] m_cnt;

   function automatic logic [127:0] pack16(input logic [7:0] a [16]);
      logic [127:0] p;
      for (int k = 0; k < 16; k++) p[k*8 +: 8] = a[k];
      return p;
   endfunction

   always @(negedge clk) begin
      bit exp_rdy, exp_vld;
      logic [63:0] row;
      if (!rstn) begin
         for (int k = 0; k < 16; k++) begin m_u[k] = 8'd0; m_v[k] = 8'd0; end
         m_rows = 0; m_calc = 0; m_out.delete(); m_cnt = '0;
      end else begin
         exp_vld = (m_out.size() != 0);
         exp_rdy = !m_calc && !exp_vld;
         chk("in_ready", 256'(o_in_ready), 256'(exp_rdy));
         chk("out_valid", 256'(o_out_valid), 256'(exp_vld));
         chk("busy", 256'(o_busy), 256'(!exp_rdy));
         if (exp_vld) chk("row_m", 256'(o_row_m), 256'(m_out[0]));
         chk("mtx_u", 256'(o_mtx_u), 256'(pack16(m_u)));
         chk("mtx_v", 256'(o_mtx_v), 256'(pack16(m_v)));
`ifdef ELEMWISE_CTRL_CNT_EN
         chk("done_cnt", 256'(o_done_cnt), 256'(m_cnt));
`endif
         // what the next rising edge does
         if (i_clear) begin
            m_rows = 0; m_calc = 0; m_out.delete();
         end else if (exp_rdy && i_in_valid) begin
            for (int c = 0; c < 4; c++) begin
               m_u[m_rows*4+c] = i_row_u[c*8 +: 8];
               m_v[m_rows*4+c] = i_row_v[c*8 +: 8];
            end
            m_rows++;
            if (m_rows == 4) begin m_rows = 0; m_calc = 1; end
         end else if (m_calc) begin
            m_calc = 0;
            for (int r = 0; r < 4; r++) begin
               for (int c = 0; c < 4; c++)
                  row[c*16 +: 16] = 16'(m_u[r*4+c]) * 16'(m_v[r*4+c]);
               m_out.push_back(row);
            end
         end else if (exp_vld && i_out_ready) begin
            void'(m_out.pop_front());
            if (m_out.size() == 0) m_cnt = m_cnt + CNT_W'(1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [31:0] u, input logic [31:0] v);
      bit ok = 0;
      i_row_u = u; i_row_v = v; i_in_valid = 1'b1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (o_in_ready) begin ok = 1; break; end
      end
      chk("in_accept_timeout", 256'(ok), 256'(1));
      @(posedge clk); #1;
      i_in_valid = 1'b0;
   endtask

   task automatic send_mtx(input logic [7:0] u [16], input logic [7:0] v [16], input int gap);
      logic [31:0] ru, rv;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            ru[c*8 +: 8] = u[r*4+c];
            rv[c*8 +: 8] = v[r*4+c];
         end
         send_beat(ru, rv);
         if (r < 3) for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_load();
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (o_in_ready) begin ok = 1; break; end
      end
      chk("drain_timeout", 256'(ok), 256'(1));
      @(posedge clk); #1;
   endtask

   task automatic run_pinned(input string nm, input logic [7:0] u [16], input logic [7:0] v [16],
                             input int gap, input logic [63:0] exp0);
      i_out_ready = 1'b0;
      send_mtx(u, v, gap);
      @(negedge clk);
      chk({nm, "_calc_no_valid"}, 256'(o_out_valid), 256'(0));
      @(negedge clk);
      chk({nm, "_t2_valid"}, 256'(o_out_valid), 256'(1));
      chk({nm, "_row0"}, 256'(o_row_m), 256'(exp0));
      @(posedge clk); #1;
      i_out_ready = 1'b1;
      wait_load();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] u [16];
      logic [7:0] v [16];
      logic [CNT_W-1:0] cnt0;
      bit ok;
      rstn = 1'b0; i_clear = 0; i_in_valid = 0; i_out_ready = 1;
      i_row_u = '0; i_row_v = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;

      // basic 3*5
      for (int k = 0; k < 16; k++) begin u[k] = 8'd3; v[k] = 8'd5; end
      run_pinned("basic", u, v, 0, {4{16'd15}});
      // max values
      for (int k = 0; k < 16; k++) begin u[k] = 8'hFF; v[k] = 8'hFF; end
      run_pinned("max", u, v, 0, {4{16'hFE01}});
      // element k = k*(k+1), with input gaps
      for (int k = 0; k < 16; k++) begin u[k] = 8'(k); v[k] = 8'(k+1); end
      run_pinned("ramp_gaps", u, v, 1, {16'd12, 16'd6, 16'd2, 16'd0});

      // backpressure on row 1
      for (int k = 0; k < 16; k++) begin u[k] = 8'($urandom); v[k] = 8'($urandom); end
      i_out_ready = 1'b0;
      send_mtx(u, v, 0);
      ok = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (o_out_valid) begin ok = 1; break; end
      end
      chk("bp_valid_timeout", 256'(ok), 256'(1));
      @(posedge clk); #1 i_out_ready = 1'b1;
      @(posedge clk); #1 i_out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      i_out_ready = 1'b1;
      wait_load();

      // abort after two beats, then a full matrix
      cnt0 = o_done_cnt;
      send_beat({4{8'd9}}, {4{8'd9}});
      send_beat({4{8'd9}}, {4{8'd9}});
      i_clear = 1'b1;
      @(posedge clk); #1 i_clear = 1'b0;
      for (int k = 0; k < 16; k++) begin u[k] = 8'd2; v[k] = 8'd7; end
      run_pinned("abort", u, v, 0, {4{16'd14}});
`ifdef ELEMWISE_CTRL_CNT_EN
      chk("abort_cnt", 256'(o_done_cnt), 256'(cnt0 + CNT_W'(1)));
`endif

      // async reset in the middle of DRAIN
      for (int k = 0; k < 16; k++) begin u[k] = 8'($urandom); v[k] = 8'($urandom); end
      i_out_ready = 1'b0;
      send_mtx(u, v, 0);
      @(posedge clk); #1;
      @(posedge clk); #3 rstn = 1'b0;
      #1;
      chk("rst_out_valid", 256'(o_out_valid), 256'(0));
      chk("rst_mtx_u", 256'(o_mtx_u), 256'(0));
      chk("rst_busy", 256'(o_busy), 256'(0));
`ifdef ELEMWISE_CTRL_CNT_EN
      chk("rst_cnt", 256'(o_done_cnt), 256'(0));
`endif
      @(posedge clk); #1;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 256'(o_in_ready), 256'(1));
      @(posedge clk); #1;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         i_in_valid  = ($urandom_range(0, 2) != 0);
         i_row_u     = $urandom;
         i_row_v     = $urandom;
         i_out_ready = ($urandom_range(0, 3) != 0);
         i_clear     = ($urandom_range(0, 59) == 0);
         @(posedge clk); #1;
      end
      i_in_valid = 0; i_clear = 0; i_out_ready = 1;
      wait_load();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
`default_nettype wire
